// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions and sequencer states.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LSB  = 8;
    localparam int CA_EXC_LSB = 2;
    localparam int CA_IP_LSB  = 8;
    localparam int CA_DF      = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VECTOR  = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } cp0_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt level, plus a one-cycle rising-edge pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic rise
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], irq_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: STATUS/CAUSE/EPC, overflow and interrupt take, eret return.
// Defining CP0_TIMER_EN adds COUNT/COMPARE and an internal timer interrupt below all external lines.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] VEC_ADDR = 32'h0000_0080,
    parameter int          WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic [WIDTH-1:0]   pc_ex,
    input  logic               ovf,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [WIDTH-1:0]   cp0_wdata,
    output logic [WIDTH-1:0]   cp0_rdata,
    output logic               flush,
    output logic               redirect,
    output logic [WIDTH-1:0]   redirect_pc,
    output logic               in_handler,
    output logic [NUM_IRQ-1:0] irq_ack
);

`ifdef CP0_TIMER_EN
    localparam int IPW = NUM_IRQ + 1;
`else
    localparam int IPW = NUM_IRQ;
`endif

    cp0_state_e         state_q, state_d;
    logic               ie_q, ie_d, exl_q, exl_d, df_q, df_d;
    logic [IPW-1:0]     im_q, im_d, ip_q, ip_d;
    logic [4:0]         exc_q, exc_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic               redirect_q, redirect_d;
    logic [WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
    logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
`ifdef CP0_TIMER_EN
    logic [WIDTH-1:0]   count_q, count_d, compare_q, compare_d;
`endif

    logic [NUM_IRQ-1:0] irq_rise;
    logic [IPW-1:0]     set_vec, pend_vec, svc;
    logic               take_ovf, take_irq, flush_c;
    logic               wr_status, wr_cause, wr_epc;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_in (irq[g]),
            .rise   (irq_rise[g])
        );
    end

    always_comb begin
        set_vec              = '0;
        set_vec[NUM_IRQ-1:0] = irq_rise;
`ifdef CP0_TIMER_EN
        set_vec[NUM_IRQ]     = (count_q == compare_q);
`endif
    end

    always_comb begin
        pend_vec  = ip_q & im_q;
        take_ovf  = (state_q == ST_IDLE) && ovf && inst_valid;
        take_irq  = (state_q == ST_IDLE) && !take_ovf && (|pend_vec) && ie_q && !exl_q && inst_valid;
        // Two's-complement trick isolates the lowest pending index.
        svc       = take_irq ? (pend_vec & (~pend_vec + IPW'(1))) : '0;
        wr_status = cp0_we && (cp0_addr == CP0_STATUS);
        wr_cause  = cp0_we && (cp0_addr == CP0_CAUSE);
        wr_epc    = cp0_we && (cp0_addr == CP0_EPC);

        state_d       = state_q;
        ie_d          = wr_status ? cp0_wdata[ST_IE]  : ie_q;
        exl_d         = wr_status ? cp0_wdata[ST_EXL] : exl_q;
        im_d          = wr_status ? cp0_wdata[ST_IM_LSB +: IPW] : im_q;
        epc_d         = wr_epc ? cp0_wdata : epc_q;
        exc_d         = exc_q;
        df_d          = df_q & ~(wr_cause & cp0_wdata[CA_DF]);
        // A fresh edge re-arms its bit even against a same-cycle W1C or service clear.
        ip_d          = (ip_q & ~(wr_cause ? cp0_wdata[CA_IP_LSB +: IPW] : '0) & ~svc) | set_vec;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        irq_ack_d     = svc[NUM_IRQ-1:0];
        flush_c       = 1'b0;
`ifdef CP0_TIMER_EN
        count_d   = (cp0_we && (cp0_addr == CP0_COUNT)) ? cp0_wdata : count_q + WIDTH'(1);
        compare_d = compare_q;
        if (cp0_we && (cp0_addr == CP0_COMPARE)) begin
            compare_d     = cp0_wdata;
            ip_d[NUM_IRQ] = 1'b0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (take_ovf || take_irq) begin
                    flush_c       = 1'b1;
                    epc_d         = pc_ex;
                    exc_d         = take_ovf ? EXC_OV : EXC_INT;
                    exl_d         = 1'b1;
                    state_d       = ST_VECTOR;
                    redirect_d    = 1'b1;
                    redirect_pc_d = WIDTH'(VEC_ADDR);
                end
            end
            ST_VECTOR: state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (ovf && inst_valid) begin
                    flush_c = 1'b1;
                    df_d    = 1'b1;
                end else if (eret) begin
                    state_d       = ST_RETURN;
                    redirect_d    = 1'b1;
                    redirect_pc_d = epc_d;
                end
            end
            ST_RETURN: begin
                exl_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            df_q          <= 1'b0;
            im_q          <= '0;
            ip_q          <= '0;
            exc_q         <= '0;
            epc_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            irq_ack_q     <= '0;
`ifdef CP0_TIMER_EN
            count_q       <= '0;
            compare_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            df_q          <= df_d;
            im_q          <= im_d;
            ip_q          <= ip_d;
            exc_q         <= exc_d;
            epc_q         <= epc_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            irq_ack_q     <= irq_ack_d;
`ifdef CP0_TIMER_EN
            count_q       <= count_d;
            compare_q     <= compare_d;
`endif
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_STATUS: begin
                cp0_rdata[ST_IE]              = ie_q;
                cp0_rdata[ST_EXL]             = exl_q;
                cp0_rdata[ST_IM_LSB +: IPW]   = im_q;
            end
            CP0_CAUSE: begin
                cp0_rdata[CA_EXC_LSB +: 5]    = exc_q;
                cp0_rdata[CA_IP_LSB +: IPW]   = ip_q;
                cp0_rdata[CA_DF]              = df_q;
            end
            CP0_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   cp0_rdata = count_q;
            CP0_COMPARE: cp0_rdata = compare_q;
`endif
            default: ;
        endcase
    end

    assign flush       = flush_c & ~rst;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign in_handler  = exl_q;
    assign irq_ack     = irq_ack_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then random traffic, checked against a reference model.
module tb_cp0_exc_ctrl;

    localparam int          NUM_IRQ = 4;
    localparam int          WIDTH   = 32;
    localparam logic [31:0] VEC     = 32'h0000_0080;
`ifdef CP0_TIMER_EN
    localparam int IPW = NUM_IRQ + 1;
`else
    localparam int IPW = NUM_IRQ;
`endif
    localparam int EW = 1 + 1 + WIDTH + 1 + NUM_IRQ + WIDTH;
    localparam int M_IDLE = 0, M_VEC = 1, M_HND = 2, M_RET = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               inst_valid = 1'b0, ovf = 1'b0, eret = 1'b0, cp0_we = 1'b0;
    logic [WIDTH-1:0]   pc_ex = '0, cp0_wdata = '0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [4:0]         cp0_addr = '0;
    logic [WIDTH-1:0]   cp0_rdata, redirect_pc;
    logic               flush, redirect, in_handler;
    logic [NUM_IRQ-1:0] irq_ack;

    cp0_exc_ctrl #(.NUM_IRQ(NUM_IRQ), .VEC_ADDR(VEC), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_ex(pc_ex), .ovf(ovf), .eret(eret),
        .irq(irq), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .in_handler(in_handler), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Reference model state
    int                 mode;
    logic               m_ie, m_exl, m_df;
    logic [IPW-1:0]     m_im, m_ip;
    logic [4:0]         m_exc;
    logic [31:0]        m_epc, m_count, m_compare;
    logic [NUM_IRQ-1:0] m_ack, h1, h2, h3;
    logic               d_ovf, d_irq;
    int                 d_line;

    logic [EW-1:0]      exp_q[$];
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [NUM_IRQ-1:0] irq_r = '0;

    task automatic model_reset();
        mode = M_IDLE; m_ie = 0; m_exl = 0; m_df = 0; m_im = '0; m_ip = '0; m_exc = '0;
        m_epc = '0; m_count = '0; m_compare = '0; m_ack = '0; h1 = '0; h2 = '0; h3 = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            5'd12: begin r[0] = m_ie; r[1] = m_exl; r[8 +: IPW] = m_im; end
            5'd13: begin r[6:2] = m_exc; r[8 +: IPW] = m_ip; r[31] = m_df; end
            5'd14: r = m_epc;
`ifdef CP0_TIMER_EN
            5'd9:  r = m_count;
            5'd11: r = m_compare;
`endif
            default: ;
        endcase
        return r;
    endfunction

    // Decide this cycle's response from the current inputs and push what the DUT must show.
    task automatic model_eval();
        logic [IPW-1:0] p;
        logic           e_flush, e_redir;
        logic [31:0]    e_rpc;
        p = m_ip & m_im;
        d_line = -1;
        for (int i = 0; i < IPW; i++) if (p[i] && d_line < 0) d_line = i;
        d_ovf   = !rst && mode == M_IDLE && ovf && inst_valid;
        d_irq   = !rst && mode == M_IDLE && !d_ovf && d_line >= 0 && m_ie && !m_exl && inst_valid;
        e_flush = d_ovf || d_irq || (!rst && mode == M_HND && ovf && inst_valid);
        e_redir = (mode == M_VEC) || (mode == M_RET);
        e_rpc   = (mode == M_VEC) ? VEC : (mode == M_RET) ? m_epc : 32'h0;
        exp_q.push_back({e_flush, e_redir, e_rpc, m_exl, m_ack, model_read(cp0_addr)});
    endtask

    task automatic model_step();
        logic [IPW-1:0] newb, w1c, n_ip;
        int             om;
        om   = mode;
        newb = '0;
        newb[NUM_IRQ-1:0] = h2 & ~h3;
`ifdef CP0_TIMER_EN
        newb[NUM_IRQ] = (m_count == m_compare);
`endif
        w1c  = (cp0_we && cp0_addr == 5'd13) ? cp0_wdata[8 +: IPW] : '0;
        n_ip = m_ip & ~w1c;
        if (d_irq) n_ip[d_line] = 1'b0;
        n_ip = n_ip | newb;
`ifdef CP0_TIMER_EN
        if (cp0_we && cp0_addr == 5'd11) begin n_ip[NUM_IRQ] = 1'b0; m_compare = cp0_wdata; end
        m_count = (cp0_we && cp0_addr == 5'd9) ? cp0_wdata : m_count + 1;
`endif
        m_ip  = n_ip;
        m_ack = '0;
        if (d_irq && d_line < NUM_IRQ) m_ack[d_line] = 1'b1;
        if (cp0_we && cp0_addr == 5'd12) begin
            m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; m_im = cp0_wdata[8 +: IPW];
        end
        if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
        if (cp0_we && cp0_addr == 5'd13 && cp0_wdata[31]) m_df = 1'b0;
        case (om)
            M_IDLE: if (d_ovf || d_irq) begin
                m_exl = 1'b1; m_epc = pc_ex; m_exc = d_ovf ? 5'd12 : 5'd0; mode = M_VEC;
            end
            M_VEC: mode = M_HND;
            M_HND: if (ovf && inst_valid) m_df = 1'b1; else if (eret) mode = M_RET;
            default: begin m_exl = 1'b0; mode = M_IDLE; end
        endcase
        h3 = h2; h2 = h1; h1 = irq;
    endtask

    task automatic drive_cycle(input logic r, input logic iv, input logic [31:0] pc, input logic o,
                               input logic e, input logic we, input logic [4:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = r; inst_valid = iv; pc_ex = pc; ovf = o; eret = e; irq = irq_r;
        cp0_we = we; cp0_addr = a; cp0_wdata = wd;
        if (r) model_reset();
        #1 model_eval();
        @(posedge clk);
        if (!rst) model_step();
    endtask

    task automatic step(input logic iv, input logic [31:0] pc, input logic o, input logic e,
                        input logic we, input logic [4:0] a, input logic [31:0] wd);
        drive_cycle(1'b0, iv, pc, o, e, we, a, wd);
    endtask

    task automatic idle_read(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'(12 + (i % 3)), 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: pops one expected record per cycle and compares every output.
    initial begin
        logic [EW-1:0]      ex;
        logic               e_flush, e_redir, e_inh;
        logic [31:0]        e_rpc, e_rdata;
        logic [NUM_IRQ-1:0] e_ack;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                {e_flush, e_redir, e_rpc, e_inh, e_ack, e_rdata} = ex;
                check("flush", 32'(flush), 32'(e_flush));
                check("redirect", 32'(redirect), 32'(e_redir));
                check("redirect_pc", redirect_pc, e_rpc);
                check("in_handler", 32'(in_handler), 32'(e_inh));
                check("irq_ack", 32'(irq_ack), 32'(e_ack));
                check("cp0_rdata", cp0_rdata, e_rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'(12 + i), 32'h0);

        // Overflow take, vector, then eret back to EPC
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0);
        idle_read(3);
        step(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 5'd13, 32'h0);
        idle_read(3);

        // Two pending lines: lowest index first, then the other after eret
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0501);
        irq_r[2] = 1'b1; idle_read(4);
        irq_r[0] = 1'b1; idle_read(4);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        idle_read(3);
        step(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        idle_read(3);
        step(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 5'd13, 32'h0);
        idle_read(2);

        // Overflow beats a pending interrupt; overflow inside the handler sets DF only
        irq_r[2] = 1'b0; idle_read(3);
        irq_r[2] = 1'b1; idle_read(4);
        step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0);
        idle_read(2);
        step(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0);
        idle_read(3);
        step(1'b1, 32'h308, 1'b0, 1'b1, 1'b0, 5'd13, 32'h0);
        idle_read(2);
        step(1'b1, 32'h310, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        idle_read(3);
        step(1'b1, 32'h314, 1'b0, 1'b1, 1'b1, 5'd13, 32'h8000_0000);
        idle_read(3);

        // W1C colliding with a new edge on the same bit; IE=0 blocks the take
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0500);
        irq_r[0] = 1'b0; idle_read(3);
        irq_r[0] = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_0500);
        idle_read(3);

        // Reset asserted during VECTOR
        step(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0);
        drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h0);
        idle_read(6);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic        iv, o, e, we;
            logic [4:0]  a;
            logic [31:0] wd;
            int          line;
            iv = ($urandom_range(3) != 0);
            o  = iv && ($urandom_range(11) == 0);
            e  = iv && !o && ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) begin
                line = $urandom_range(NUM_IRQ - 1);
                irq_r[line] = ~irq_r[line];
            end
            we = ($urandom_range(9) == 0);
            case ($urandom_range(5))
                0: a = 5'd12;
                1: a = 5'd13;
                2: a = 5'd14;
                3: a = 5'd9;
                4: a = 5'd11;
                default: a = 5'($urandom_range(31));
            endcase
            wd = $urandom;
            if (we && a == 5'd12) begin
                wd[0] = ($urandom_range(7) != 0);
                wd[1] = ($urandom_range(7) == 0);
            end
            step(iv, $urandom & 32'hFFFF_FFFC, o, e, we, a, wd);
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt sequencer for the single-issue MIPS-style core. Watches the EX stage for overflow (ovcntrl-class instructions) and for enabled external interrupts. Holds the STATUS, CAUSE and EPC registers and services mtc0/mfc0 accesses. Flushes the faulting instruction, redirects fetch to the handler vector, and returns to EPC on eret.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..8)
VEC_ADDR, 32'h0000_0080, handler entry address
WIDTH, 32, data/PC width

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
inst_valid  in  1  EX stage holds a valid instruction
pc_ex  in  WIDTH  PC of the EX-stage instruction
ovf  in  1  ALU signed overflow on an ovcntrl instruction in EX
eret  in  1  eret decoded in EX
irq  in  NUM_IRQ  asynchronous interrupt levels
cp0_we  in  1  mtc0 write strobe
cp0_addr  in  5  CP0 register number
cp0_wdata  in  WIDTH  mtc0 data
cp0_rdata  out  WIDTH  mfc0 data (combinational)
flush  out  1  kill EX instruction write-back/mem-write this cycle
redirect  out  1  fetch must load redirect_pc
redirect_pc  out  WIDTH  target PC
in_handler  out  1  STATUS.EXL
irq_ack  out  NUM_IRQ  one-cycle pulse for the serviced line

Behaviour:
- Registers:
  - STATUS (addr 12): bit0 IE, bit1 EXL, bits[8+:NUM_IRQ] IM.
  - CAUSE (addr 13): [6:2] ExcCode (0=Int, 12=Ov), [8+:NUM_IRQ] IP, [31] DF sticky.
  - EPC (addr 14).
  - Other addresses read 0; writes to them are ignored.
- Reset: all registers 0, state IDLE, flush/redirect/irq_ack 0, redirect_pc 0, cp0_rdata reflects the zeroed registers.
- irq path: each line passes through a 2-flop synchronizer plus rising-edge detect. An edge sets IP[i], which stays sticky until ack or a W1C write.
- Pending interrupt: |(IP & IM) && IE && !EXL && inst_valid. Lowest index wins.
- Priority: ovf beats interrupt. Interrupt and ovf in the same cycle: ovf is taken, IP is left pending.
- FSM states: IDLE, VECTOR, HANDLER, RETURN.
  - IDLE, cycle N, ovf&&inst_valid or pending interrupt:
    - flush=1 combinationally in cycle N.
    - At the edge: EPC<=pc_ex, ExcCode set, EXL<=1, serviced IP bit cleared, go to VECTOR.
    - irq_ack pulses in N+1.
  - VECTOR (one cycle): redirect=1, redirect_pc=VEC_ADDR, then go to HANDLER. Total take latency is 1 cycle.
  - HANDLER: interrupts are masked by EXL.
    - ovf: flush=1, DF<=1, EPC unchanged.
    - eret: flush=0; at the edge go to RETURN.
  - RETURN (one cycle): redirect=1, redirect_pc=EPC, EXL<=0 at the edge, go to IDLE.
- eret outside HANDLER: no effect.
- mtc0 rules:
  - STATUS: IE, EXL and IM are writable.
  - EPC: fully writable.
  - CAUSE: IP is write-1-to-clear, DF is W1C, ExcCode is read-only.
- Collisions:
  - Hardware update and mtc0 to the same field in the same cycle: hardware wins.
  - New irq edge and W1C on the same bit: set wins.
- mfc0 reads current register values with no bypass of same-cycle writes.
- rst asserted mid-sequence (VECTOR/RETURN): immediate return to reset values; no redirect is issued.

Optional Feature:
CP0_TIMER_EN:
- When defined, adds COUNT (addr 9), incremented every cycle, and COMPARE (addr 11).
- COUNT==COMPARE sets internal IP bit NUM_IRQ (mask bit IM[NUM_IRQ]), serviced below all external lines.
- Writing COMPARE clears that bit.
- When undefined: addresses 9/11 read 0, no timer IP bit exists, and the IP/IM width is NUM_IRQ.

Decomposition:
- Package cp0_pkg: CP0 register addresses (9, 11, 12, 13, 14), ExcCode constants, STATUS/CAUSE bit positions, FSM state enum.
- Sub-module irq_sync_edge: per-line 2-flop synchronizer plus rising-edge pulse, instantiated NUM_IRQ times.

Test Plan:
1. ovf=1, pc_ex=32'h40, IDLE -> flush=1 same cycle; next cycle redirect=1, redirect_pc=32'h80; EPC=32'h40, ExcCode=12, EXL=1.
2. STATUS=32'h0000_0501 (IE, IM0, IM2), irq[2] then irq[0] edges -> line 0 serviced first, irq_ack=4'b0001, IP[2] still set.
3. In HANDLER, eret -> RETURN cycle redirect_pc=EPC; EXL=0 afterwards; pending IP[2] taken on the next valid instruction.
4. ovf and a pending interrupt in the same cycle -> ExcCode=12, IP unchanged; ovf in HANDLER -> DF=1, EPC unchanged.
5. mtc0 CAUSE wdata=32'h0000_0100 in the same cycle as an irq[0] edge -> IP[0] remains 1; IE=0 -> no exception taken.
6. rst pulse during VECTOR -> redirect=0, all CP0 registers 0, state IDLE; with CP0_TIMER_EN, COMPARE=20 -> timer IP set at COUNT==20.
